// File: rtl/mux16_1_if.sv
// Bus bundle for the registered 16:1 channel selector.
// The producer (master) drives the sixteen channels, the channel index and the
// qualifier; the selector (slave) returns the registered sample and its strobe.
interface mux16_1_if #(
    parameter int WIDTH = 6
);
    logic [WIDTH-1:0] datain_0;
    logic [WIDTH-1:0] datain_1;
    logic [WIDTH-1:0] datain_2;
    logic [WIDTH-1:0] datain_3;
    logic [WIDTH-1:0] datain_4;
    logic [WIDTH-1:0] datain_5;
    logic [WIDTH-1:0] datain_6;
    logic [WIDTH-1:0] datain_7;
    logic [WIDTH-1:0] datain_8;
    logic [WIDTH-1:0] datain_9;
    logic [WIDTH-1:0] datain_10;
    logic [WIDTH-1:0] datain_11;
    logic [WIDTH-1:0] datain_12;
    logic [WIDTH-1:0] datain_13;
    logic [WIDTH-1:0] datain_14;
    logic [WIDTH-1:0] datain_15;
    logic [3:0]       select;
    logic             in_valid;
    logic [WIDTH-1:0] out;
    logic             out_valid;

    modport master (
        output datain_0, datain_1, datain_2, datain_3,
               datain_4, datain_5, datain_6, datain_7,
               datain_8, datain_9, datain_10, datain_11,
               datain_12, datain_13, datain_14, datain_15,
               select, in_valid,
        input  out, out_valid
    );

    modport slave (
        input  datain_0, datain_1, datain_2, datain_3,
               datain_4, datain_5, datain_6, datain_7,
               datain_8, datain_9, datain_10, datain_11,
               datain_12, datain_13, datain_14, datain_15,
               select, in_valid,
        output out, out_valid
    );
endinterface

// File: rtl/mux16_1.sv
// Registered 16:1 channel selector.
// A sample is taken on every clock edge where in_valid is high; the chosen
// channel appears on out one clock later together with a one-cycle out_valid.
// out holds its last value while no sample is accepted. Only the output
// registers are reset; channel data and select are plain datapath.
module mux16_1 #(
    parameter int WIDTH = 6
) (
    input  logic     clk,
    input  logic     rst_n,
    mux16_1_if.slave bus
);

    logic [WIDTH-1:0] sel_data;
    logic [WIDTH-1:0] out_d;
    logic [WIDTH-1:0] out_q;
    logic             out_valid_d;
    logic             out_valid_q;

    // Full 16-way decode of the channel index; every code maps to its own channel.
    always_comb begin
        sel_data = bus.datain_0;
        unique case (bus.select)
            4'd0:  sel_data = bus.datain_0;
            4'd1:  sel_data = bus.datain_1;
            4'd2:  sel_data = bus.datain_2;
            4'd3:  sel_data = bus.datain_3;
            4'd4:  sel_data = bus.datain_4;
            4'd5:  sel_data = bus.datain_5;
            4'd6:  sel_data = bus.datain_6;
            4'd7:  sel_data = bus.datain_7;
            4'd8:  sel_data = bus.datain_8;
            4'd9:  sel_data = bus.datain_9;
            4'd10: sel_data = bus.datain_10;
            4'd11: sel_data = bus.datain_11;
            4'd12: sel_data = bus.datain_12;
            4'd13: sel_data = bus.datain_13;
            4'd14: sel_data = bus.datain_14;
            4'd15: sel_data = bus.datain_15;
        endcase
    end

    // Next-state: load the selected channel on an accepted sample, otherwise hold.
    always_comb begin
        out_d       = out_q;
        out_valid_d = 1'b0;
        if (bus.in_valid) begin
            out_d       = sel_data;
            out_valid_d = 1'b1;
        end
    end

    // Output registers; reset clears them immediately, discarding any in-flight sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.out       = out_q;
    assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_mux16_1.sv
// Directed bench for mux16_1 with hand-computed expected values.
module tb_mux16_1;

    localparam int WIDTH = 6;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    mux16_1_if #(.WIDTH(WIDTH)) bus ();

    mux16_1 #(.WIDTH(WIDTH)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock edge, then settle just after it so outputs are sampled away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_channels();
        bus.datain_0  = 6'd20;
        bus.datain_1  = 6'd15;
        bus.datain_2  = 6'd25;
        bus.datain_3  = 6'd10;
        bus.datain_4  = 6'd5;
        bus.datain_5  = 6'd17;
        bus.datain_6  = 6'd8;
        bus.datain_7  = 6'd16;
        bus.datain_8  = 6'd30;
        bus.datain_9  = 6'd1;
        bus.datain_10 = 6'd32;
        bus.datain_11 = 6'd50;
        bus.datain_12 = 6'd7;
        bus.datain_13 = 6'd11;
        bus.datain_14 = 6'd23;
        bus.datain_15 = 6'd14;
    endtask

    int sweep_exp [16] = '{20, 15, 25, 10, 5, 17, 8, 16, 30, 1, 32, 50, 7, 11, 23, 14};

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        bus.in_valid = 1'b0;
        bus.select   = 4'd0;
        load_channels();

        // Reset state, before any clock edge.
        #1;
        check("reset_out", 32'(bus.out), 32'd0);
        check("reset_valid", 32'(bus.out_valid), 32'd0);

        tick();
        rst_n = 1'b1;
        tick();
        check("idle_out", 32'(bus.out), 32'd0);
        check("idle_valid", 32'(bus.out_valid), 32'd0);

        // Sweep all sixteen channels back to back.
        for (int k = 0; k < 16; k++) begin
            bus.select   = 4'(k);
            bus.in_valid = 1'b1;
            tick();
            check($sformatf("sweep_out_%0d", k), 32'(bus.out), 32'(sweep_exp[k]));
            check($sformatf("sweep_valid_%0d", k), 32'(bus.out_valid), 32'd1);
        end

        // Hold: accept channel 10, then idle with a different select.
        bus.select   = 4'd10;
        bus.in_valid = 1'b1;
        tick();
        check("hold_accept_out", 32'(bus.out), 32'd32);
        bus.select   = 4'd11;
        bus.in_valid = 1'b0;
        tick();
        check("hold_out", 32'(bus.out), 32'd32);
        check("hold_valid", 32'(bus.out_valid), 32'd0);
        // Mid-cycle changes of select and data must not reach out.
        #2;
        bus.select    = 4'd0;
        bus.datain_10 = 6'd3;
        #1;
        check("between_edges_out", 32'(bus.out), 32'd32);
        tick();
        check("hold2_out", 32'(bus.out), 32'd32);
        bus.datain_10 = 6'd32;

        // Isolation: neighbour channel changes on the accepting edge.
        bus.select   = 4'd3;
        bus.datain_3 = 6'd10;
        bus.datain_2 = 6'd63;
        bus.in_valid = 1'b1;
        tick();
        check("isolation_out", 32'(bus.out), 32'd10);
        bus.datain_2 = 6'd25;

        // Width: all-ones value on the top channel.
        bus.datain_15 = 6'd63;
        bus.select    = 4'd15;
        tick();
        check("width_out", 32'(bus.out), 32'd63);
        check("width_valid", 32'(bus.out_valid), 32'd1);
        bus.datain_15 = 6'd14;

        // Async reset mid-stream.
        bus.select = 4'd11;
        tick();
        check("pre_reset_out", 32'(bus.out), 32'd50);
        check("pre_reset_valid", 32'(bus.out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_out", 32'(bus.out), 32'd0);
        check("async_reset_valid", 32'(bus.out_valid), 32'd0);
        tick();
        check("in_reset_out", 32'(bus.out), 32'd0);
        check("in_reset_valid", 32'(bus.out_valid), 32'd0);
        bus.in_valid = 1'b0;
        #2;
        rst_n = 1'b1;
        tick();
        check("post_release_out", 32'(bus.out), 32'd0);
        check("post_release_valid", 32'(bus.out_valid), 32'd0);

        // Latency: single-cycle pulse on channel 8.
        bus.select   = 4'd8;
        bus.in_valid = 1'b1;
        #3;
        check("latency_no_comb_valid", 32'(bus.out_valid), 32'd0);
        tick();
        check("latency_out", 32'(bus.out), 32'd30);
        check("latency_valid", 32'(bus.out_valid), 32'd1);
        bus.in_valid = 1'b0;
        tick();
        check("latency_valid_drop", 32'(bus.out_valid), 32'd0);
        check("latency_out_hold", 32'(bus.out), 32'd30);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mux16_1.md
MUX16_1 -- requirements
Module: mux16_1

Interface
REQ-001 Parameter WIDTH, default 6, data width of every data input and of out.
REQ-002 One clock; reset is asynchronous and active-low.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 datain_0 .. datain_15  input  WIDTH each  sixteen data channels; N in datain_N is the channel index.
REQ-006 select  input  4  channel index, unsigned, 0..15.
REQ-007 in_valid  input  1  qualifies select and the data inputs on this clock edge.
REQ-008 out  output  WIDTH  registered selected channel.
REQ-009 out_valid  output  1  high for one cycle per accepted sample.

Function
REQ-010 The selection SHALL be a full 16:1 decode: select value k picks datain_k, for every k in 0..15, with no default or fallback channel.
REQ-011 On a rising clk edge with in_valid=1, out SHALL load the datain channel picked by the select value sampled at that same edge; out_valid SHALL load 1.
REQ-012 On a rising clk edge with in_valid=0, out SHALL hold its previous value and out_valid SHALL load 0.
REQ-013 Latency SHALL be exactly one clock from the accepting edge to out/out_valid; there is no combinational path from any input to out or out_valid.
REQ-014 Back-to-back in_valid=1 cycles SHALL each produce one result, one per cycle; throughput is one sample per clock.
REQ-015 A change of select or any datain between edges SHALL have no effect on out until the next accepting edge.
REQ-016 Data SHALL pass unmodified, with no truncation, extension or arithmetic; every WIDTH-bit value, including all-ones, SHALL be reproduced bit-exact.
REQ-017 A change of a non-selected channel on an accepting edge SHALL NOT affect out.
REQ-018 The design SHALL be synthesizable with no latches; every bit of out and out_valid comes from a clk/rst_n flip-flop.

Reset
REQ-019 While rst_n=0, out SHALL be 0 and out_valid SHALL be 0, immediately and without waiting for a clk edge.
REQ-020 After rst_n returns to 1, the first rising clk edge SHALL behave per REQ-011/REQ-012.
REQ-021 Asserting rst_n mid-stream SHALL discard any in-flight result: out_valid is 0 and out is 0 during reset.
REQ-022 Channel inputs and select need no reset.

Verification
REQ-023 Sweep: load datain_0..15 = 20,15,25,10,5,17,8,16,30,1,32,50,7,11,23,14 and in_valid=1. Apply select 0..15, one per cycle, for 16 consecutive cycles. Required response: one cycle later, out = 20,15,25,10,5,17,8,16,30,1,32,50,7,11,23,14 in order, with out_valid=1 throughout.
REQ-024 Hold: with the same channel loading, accept select=10 to give out=32. Then drive in_valid=0 and select=11. Required response: out stays 32 and out_valid=0.
REQ-025 Isolation: accept with select=3 and datain_3=10, while changing datain_2 to 63 at that same edge. Required response: out=10.
REQ-026 Width: set datain_15=63 and select=15 with in_valid=1. Required response: out=63 next cycle.
REQ-027 Async reset: while out=50 and out_valid=1, pull rst_n low between edges. Required response: out=0 and out_valid=0 immediately, and they stay 0 until an accepting edge after release.
REQ-028 Latency: pulse in_valid for one cycle with select=8. Required response: out=30 and out_valid=1 exactly one edge later, and out_valid=0 on the following cycle.
